// File: rtl/cen_gen_lockseq.sv
// Fractional clock-enable generator: per-channel phase accumulators emitting carry pulses,
// gated by a PLL-lock qualification FSM that also sequences the core reset.
module cen_gen_lockseq #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = {16'd16384, 16'd4096, 16'd4096, 16'd1024}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              phase_clr,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] cen,
  output logic              ready,
  output logic              sys_rst_n
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              sync1, lk_s;
  logic              run_nxt;

  logic [ACC_W-1:0]  acc     [NUM_CH];
  logic [ACC_W-1:0]  acc_nxt [NUM_CH];
  logic [ACC_W-1:0]  inc     [NUM_CH];
  logic [ACC_W-1:0]  inc_nxt [NUM_CH];
  logic [ACC_W:0]    sum     [NUM_CH];
  logic [NUM_CH-1:0] cen_nxt;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lk_s  <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Lock qualification: LOCK_CYCLES consecutive synced-lock cycles before RUN
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lk_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lk_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lk_s) state_nxt = WAIT_LOCK;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // Accumulators run only in RUN; anything else (including phase_clr) holds them at zero
  always_comb begin
    run_nxt = (state == RUN) && (state_nxt == RUN);
    cen_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]     = {1'b0, acc[i]} + {1'b0, inc[i]};
      acc_nxt[i] = '0;
      inc_nxt[i] = inc[i];
      if ((state == RUN) && !phase_clr) begin
        acc_nxt[i] = sum[i][ACC_W-1:0];
        cen_nxt[i] = run_nxt && sum[i][ACC_W] && ch_en[i];
      end
      if (cfg_wr && (cfg_ch == 3'(i))) inc_nxt[i] = cfg_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cen       <= '0;
      ready     <= 1'b0;
      sys_rst_n <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        inc[i] <= INC_INIT[i*ACC_W +: ACC_W];
      end
    end else begin
      cen       <= cen_nxt;
      ready     <= run_nxt;
      sys_rst_n <= run_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= acc_nxt[i];
        inc[i] <= inc_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_cen_gen_lockseq.sv
// Randomised bench for cen_gen_lockseq against a streak-count / integer-phase reference model.
module tb_cen_gen_lockseq;

  localparam int LC    = 1024;
  localparam int NCH   = 4;
  localparam int MODV  = 65536;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll_locked = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_ch = 3'd0;
  logic [15:0] cfg_inc = 16'd0;
  logic        phase_clr = 1'b0;
  logic [3:0]  ch_en = 4'hF;
  logic [3:0]  cen;
  logic        ready;
  logic        sys_rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  cen_gen_lockseq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .phase_clr (phase_clr),
    .ch_en     (ch_en),
    .cen       (cen),
    .ready     (ready),
    .sys_rst_n (sys_rst_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lock streak length decides RUN, accumulators are plain integers mod 2^16
  int   m_acc [NCH];
  int   m_inc [NCH];
  bit   m_s1, m_s2;
  int   m_streak;
  bit [3:0] m_cen;
  bit   m_ready;

  function automatic int init_inc(input int ch);
    case (ch)
      0: return 1024;
      1: return 4096;
      2: return 4096;
      default: return 16384;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_streak = 0; m_cen = '0; m_ready = 0;
    for (int c = 0; c < NCH; c++) begin
      m_acc[c] = 0;
      m_inc[c] = init_inc(c);
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin : model
    bit lk_pre, in_run_pre;
    int s;
    if (!rst_n) begin
      model_reset();
    end else begin
      lk_pre     = m_s2;
      in_run_pre = (m_streak >= LC + 1);
      m_s2 = m_s1;
      m_s1 = pll_locked;
      if (lk_pre) m_streak = (m_streak < LC + 10) ? m_streak + 1 : m_streak;
      else        m_streak = 0;
      m_ready = in_run_pre && lk_pre;
      for (int c = 0; c < NCH; c++) begin
        m_cen[c] = 1'b0;
        if (in_run_pre && !phase_clr) begin
          s = m_acc[c] + m_inc[c];
          m_cen[c] = m_ready && (s >= MODV) && ch_en[c];
          m_acc[c] = s % MODV;
        end else begin
          m_acc[c] = 0;
        end
      end
      if (cfg_wr && (int'(cfg_ch) < NCH)) m_inc[int'(cfg_ch)] = int'(cfg_inc);
    end
  end

  always @(negedge clk) begin
    chk("cen", int'(cen), int'(m_cen));
    chk("ready", int'(ready), int'(m_ready));
    chk("sys_rst_n", int'(sys_rst_n), int'(m_ready));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ready is seen high; expired budget returns -1
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready) begin
      step();
      n++;
      if (n > 4000) begin
        n = -1;
        return;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int cnt [NCH], output int first [NCH]);
    for (int c = 0; c < NCH; c++) begin
      cnt[c] = 0;
      first[c] = -1;
    end
    for (int k = 1; k <= cycles; k++) begin
      step();
      for (int c = 0; c < NCH; c++) begin
        if (cen[c]) begin
          cnt[c]++;
          if (first[c] < 0) first[c] = k;
        end
      end
    end
  endtask

  int n;
  int pc [NCH];
  int pf [NCH];

  initial begin
    repeat (3) step();
    chk("reset_cen", int'(cen), 0);
    chk("reset_ready", int'(ready), 0);
    chk("reset_sys_rst_n", int'(sys_rst_n), 0);

    // Lock-up latency from reset release with PLL already locked
    rst_n = 1'b1;
    wait_ready(n);
    chk("lock_latency", n, LC + 4);

    // Default increments after a phase re-align
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    count_pulses(256, pc, pf);
    chk("def_ch0_cnt", pc[0], 4);
    chk("def_ch1_cnt", pc[1], 16);
    chk("def_ch2_cnt", pc[2], 16);
    chk("def_ch3_cnt", pc[3], 64);
    chk("def_ch3_first", pf[3], 4);
    chk("def_ch1_first", pf[1], 16);
    chk("def_ch2_first", pf[2], 16);

    // One-third rate with simultaneous cfg write and phase clear
    cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_inc = 16'h5555; phase_clr = 1'b1;
    step();
    cfg_wr = 1'b0; phase_clr = 1'b0;
    count_pulses(3000, pc, pf);
    chk("third_ch1_cnt", pc[1], 999);
    chk("third_ch1_first", pf[1], 4);

    // Masking ch3 suppresses pulses only
    ch_en = 4'b0111;
    count_pulses(10, pc, pf);
    chk("mask_ch3_cnt", pc[3], 0);
    ch_en = 4'hF;
    repeat (20) step();

    // Randomised traffic including out-of-range channels and rare lock drops
    for (int k = 0; k < 3000; k++) begin
      ch_en     = 4'($urandom_range(0, 15));
      cfg_wr    = ($urandom_range(0, 15) == 0);
      cfg_ch    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: cfg_inc = 16'h0000;
        1: cfg_inc = 16'hFFFF;
        default: cfg_inc = 16'($urandom_range(0, 65535));
      endcase
      phase_clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 999) == 0) pll_locked = 1'b0;
      else if (!pll_locked && $urandom_range(0, 3) == 0) pll_locked = 1'b1;
      step();
    end
    cfg_wr = 1'b0; phase_clr = 1'b0; pll_locked = 1'b1; ch_en = 4'hF;

    // Lock loss in RUN
    wait_ready(n);
    chk("relock_timeout", int'(n >= 0), 1);
    repeat (5) step();
    pll_locked = 1'b0;
    repeat (3) step();
    chk("runglitch_sys_rst_n", int'(sys_rst_n), 0);
    chk("runglitch_cen", int'(cen), 0);
    pll_locked = 1'b1;

    // One-cycle glitch while qualifying lock restarts the count
    repeat (500) step();
    chk("stable_not_ready", int'(ready), 0);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    n = 1;
    while (!ready && n <= 4000) begin
      step();
      n++;
    end
    chk("glitch_latency", n, LC + 5);

    // Async reset mid-RUN restores reset values and default increments
    cfg_wr = 1'b1; cfg_ch = 3'd3; cfg_inc = 16'd100;
    step();
    cfg_wr = 1'b0;
    repeat (7) step();
    chk("pre_reset_ready", int'(ready), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_cen", int'(cen), 0);
    chk("async_ready", int'(ready), 0);
    chk("async_sys_rst_n", int'(sys_rst_n), 0);
    step();
    step();
    rst_n = 1'b1;
    wait_ready(n);
    chk("post_reset_latency", n, LC + 4);
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    count_pulses(256, pc, pf);
    chk("post_reset_ch3_cnt", pc[3], 64);
    chk("post_reset_ch0_cnt", pc[0], 4);

    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
